// File: rtl/pe_array_seq_pkg.sv
// Shared types and helpers for the parametrised PE array and its config sequencer.
// Bus-width defaults are the values of the legacy Config_W / C_L_bus / R_Q / W_Q / A_bus.
package pe_array_seq_pkg;

    localparam int CONFIG_W = 80;
    localparam int C_L_BUS  = 32;
    localparam int R_Q      = 3;
    localparam int W_Q      = 3;
    localparam int A_BUS    = 144;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_INIT,
        ST_ARMED,
        ST_RUN
    } seq_state_t;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    // Counter width that stays legal when only one value is ever needed.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/PE_row.sv
// Behavioural model of one 3-column PE row: forwards CBG data onto the N/S links
// and exposes config, links, init and run on its LSU-side buses.
module PE_row
    import pe_array_seq_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CFG_W  = CONFIG_W,
    parameter int CL_W   = C_L_BUS,
    parameter int RQ_W   = R_Q,
    parameter int WQ_W   = W_Q,
    parameter int AB_W   = A_BUS
) (
    input  logic              init,
    input  logic              run,
    input  logic [CFG_W-1:0]  cfg,
    input  logic [DATA_W-1:0] Nin,
    input  logic [DATA_W-1:0] Sin,
    input  logic [CL_W-1:0]   CBG_to_LSU_bus,
    output logic [DATA_W-1:0] Nout,
    output logic [DATA_W-1:0] Sout,
    output logic [RQ_W-1:0]   R_request,
    output logic [WQ_W-1:0]   W_request,
    output logic [AB_W-1:0]   LSU_addr_bus
);

    assign Nout         = DATA_W'(CBG_to_LSU_bus);
    assign Sout         = ~(DATA_W'(CBG_to_LSU_bus));
    assign R_request    = {RQ_W{run}};
    assign W_request    = {WQ_W{init}};
    assign LSU_addr_bus = AB_W'({Sin, Nin, cfg});

endmodule

// File: rtl/pe_cfg_loader.sv
// Array sequencer: streams per-row config words in, pulses init, then runs the
// array for a programmed number of cycles.
module pe_cfg_loader
    import pe_array_seq_pkg::*;
#(
    parameter int ROWS   = 4,
    parameter int CFG_W  = CONFIG_W,
    parameter int WORD_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [WORD_W-1:0]     cfg_data,
    input  logic                  run_req,
    input  logic [LEN_W-1:0]      run_len,
    output logic                  busy,
    output logic                  armed,
    output logic                  done,
    output logic                  row_init,
    output logic                  row_run,
    output logic [ROWS*CFG_W-1:0] row_cfg
);

    localparam int BEATS   = ceil_div(CFG_W, WORD_W);
    localparam int BEAT_CW = cnt_w(BEATS);
    localparam int ROW_CW  = cnt_w(ROWS);
    localparam logic [BEAT_CW-1:0] LAST_BEAT = BEAT_CW'(BEATS - 1);
    localparam logic [ROW_CW-1:0]  LAST_ROW  = ROW_CW'(ROWS - 1);

    seq_state_t                   state;
    seq_state_t                   state_n;
    logic [BEAT_CW-1:0]           beat_cnt;
    logic [ROW_CW-1:0]            row_cnt;
    logic [LEN_W-1:0]             run_cnt;
    logic [BEATS-1:0][WORD_W-1:0] shadow;
    logic [BEATS-1:0][WORD_W-1:0] shadow_n;
    logic [CFG_W-1:0]             cfg_q [ROWS];
    logic                         beat_fire;
    logic                         row_done;
    logic                         reconfig;

    assign beat_fire = (state == ST_LOAD) && cfg_valid;
    assign row_done  = beat_fire && (beat_cnt == LAST_BEAT);
    assign reconfig  = start && ((state == ST_IDLE) || (state == ST_ARMED));

    // Shadow with the incoming beat merged in, so the final beat commits in the same cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        shadow_n           = shadow;
        shadow_n[beat_cnt] = cfg_data;
    end

    always_comb begin
        state_n = state;
        if (abort) begin
            state_n = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (start) state_n = ST_LOAD;
                ST_LOAD:  if (row_done && (row_cnt == LAST_ROW)) state_n = ST_INIT;
                ST_INIT:  state_n = ST_ARMED;
                ST_ARMED: begin
                    if (start)                            state_n = ST_LOAD;
                    else if (run_req && (run_len != '0))  state_n = ST_RUN;
                end
                ST_RUN:   if (run_cnt == LEN_W'(1)) state_n = ST_ARMED;
                default:  state_n = ST_IDLE;
            endcase
        end
    end

    // NOTE: all state here uses <= so every flop samples pre-edge values whatever the statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cfg_ready <= 1'b0;
            busy      <= 1'b0;
            armed     <= 1'b0;
            done      <= 1'b0;
            row_init  <= 1'b0;
            row_run   <= 1'b0;
            beat_cnt  <= '0;
            row_cnt   <= '0;
            run_cnt   <= '0;
            shadow    <= '0;
            // NOTE: the config array is a flop array, not RAM, so it can and must be cleared on reset.
            for (int r = 0; r < ROWS; r++) begin
                cfg_q[r] <= '0;
            end
        end else begin
            state     <= state_n;
            cfg_ready <= (state_n == ST_LOAD);
            busy      <= (state_n == ST_LOAD) || (state_n == ST_INIT) || (state_n == ST_RUN);
            armed     <= (state_n == ST_ARMED);
            row_init  <= (state_n == ST_INIT);
            row_run   <= (state_n == ST_RUN);
            done      <= 1'b0;

            if (abort || reconfig) begin
                // Committed rows survive; only in-flight load/run progress is dropped.
                beat_cnt <= '0;
                row_cnt  <= '0;
                run_cnt  <= '0;
                shadow   <= '0;
            end else begin
                case (state)
                    ST_LOAD: begin
                        if (beat_fire) begin
                            shadow <= shadow_n;
                            if (row_done) begin
                                beat_cnt       <= '0;
                                cfg_q[row_cnt] <= CFG_W'(shadow_n);
                                row_cnt        <= (row_cnt == LAST_ROW) ? '0 : row_cnt + 1'b1;
                            end else begin
                                beat_cnt <= beat_cnt + 1'b1;
                            end
                        end
                    end
                    ST_ARMED: begin
                        if (run_req) begin
                            if (run_len == '0) done    <= 1'b1;
                            else               run_cnt <= run_len;
                        end
                    end
                    ST_RUN: begin
                        run_cnt <= run_cnt - 1'b1;
                        if (run_cnt == LEN_W'(1)) done <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_cfg_out
        assign row_cfg[r*CFG_W +: CFG_W] = cfg_q[r];
    end

endmodule

// File: rtl/pe_array_seq.sv
// Parametrised PE array: ROWS chained PE_row instances with optional registered
// N/S links, driven by the on-array config/run sequencer.
module pe_array_seq
    import pe_array_seq_pkg::*;
#(
    parameter int ROWS    = 4,
    parameter int DATA_W  = 32,
    parameter int CFG_W   = CONFIG_W,
    parameter int WORD_W  = 32,
    parameter int CL_W    = C_L_BUS,
    parameter int RQ_W    = R_Q,
    parameter int WQ_W    = W_Q,
    parameter int AB_W    = A_BUS,
    parameter int PIPE_NS = 0,
    parameter int LEN_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [WORD_W-1:0]    cfg_data,
    input  logic                 run_req,
    input  logic [LEN_W-1:0]     run_len,
    output logic                 busy,
    output logic                 armed,
    output logic                 done,
    input  logic [ROWS*CL_W-1:0] CBG_to_LSU_bus,
    output logic [ROWS*RQ_W-1:0] R_request,
    output logic [ROWS*WQ_W-1:0] W_request,
    output logic [ROWS*AB_W-1:0] LSU_addr_bus
);

    logic                  row_init;
    logic                  row_run;
    logic [ROWS*CFG_W-1:0] row_cfg;
    logic [DATA_W-1:0]     nout [ROWS];
    logic [DATA_W-1:0]     sout [ROWS];
    logic [DATA_W-1:0]     nin  [ROWS];
    logic [DATA_W-1:0]     sin  [ROWS];

    pe_cfg_loader #(
        .ROWS   (ROWS),
        .CFG_W  (CFG_W),
        .WORD_W (WORD_W),
        .LEN_W  (LEN_W)
    ) u_loader (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_data  (cfg_data),
        .run_req   (run_req),
        .run_len   (run_len),
        .busy      (busy),
        .armed     (armed),
        .done      (done),
        .row_init  (row_init),
        .row_run   (row_run),
        .row_cfg   (row_cfg)
    );

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        PE_row #(
            .DATA_W (DATA_W),
            .CFG_W  (CFG_W),
            .CL_W   (CL_W),
            .RQ_W   (RQ_W),
            .WQ_W   (WQ_W),
            .AB_W   (AB_W)
        ) u_row (
            .init           (row_init),
            .run            (row_run),
            .cfg            (row_cfg[r*CFG_W +: CFG_W]),
            .Nin            (nin[r]),
            .Sin            (sin[r]),
            .CBG_to_LSU_bus (CBG_to_LSU_bus[r*CL_W +: CL_W]),
            .Nout           (nout[r]),
            .Sout           (sout[r]),
            .R_request      (R_request[r*RQ_W +: RQ_W]),
            .W_request      (W_request[r*WQ_W +: WQ_W]),
            .LSU_addr_bus   (LSU_addr_bus[r*AB_W +: AB_W])
        );
    end

    // Hop h joins row h (south side) and row h+1 (north side).
    for (genvar h = 0; h < ROWS - 1; h++) begin : g_hop
        if (PIPE_NS != 0) begin : g_pipe
            logic [DATA_W-1:0] up_q;
            logic [DATA_W-1:0] dn_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    up_q <= '0;
                    dn_q <= '0;
                end else begin
                    up_q <= nout[h+1];
                    dn_q <= sout[h];
                end
            end

            assign sin[h]   = up_q;
            assign nin[h+1] = dn_q;
        end else begin : g_wire
            assign sin[h]   = nout[h+1];
            assign nin[h+1] = sout[h];
        end
    end

    assign nin[0]      = '0;
    assign sin[ROWS-1] = '0;

    // The outward-facing links of the end rows go nowhere.
    logic unused_edge_links;
    assign unused_edge_links = ^{nout[0], sout[ROWS-1]};

endmodule

// File: tb/tb_pe_array_seq.sv
// Self-checking bench for pe_array_seq: one instance with combinational N/S links
// and one with registered links share all stimulus.
module tb_pe_array_seq;

    localparam int ROWS   = 4;
    localparam int DATA_W = 32;
    localparam int CFG_W  = 80;
    localparam int WORD_W = 32;
    localparam int CL_W   = 32;
    localparam int RQ_W   = 3;
    localparam int WQ_W   = 3;
    localparam int AB_W   = 144;
    localparam int LEN_W  = 16;

    localparam int NIN_LSB = CFG_W;
    localparam int SIN_LSB = CFG_W + DATA_W;

    typedef struct {
        int row;
        logic [CFG_W-1:0] cfg;
    } cfg_vec_t;

    typedef struct {
        int run_len;
        bit poke_start;
        int exp_cycles;
    } run_vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic                 start;
    logic                 abort;
    logic                 cfg_valid;
    logic [WORD_W-1:0]    cfg_data;
    logic                 run_req;
    logic [LEN_W-1:0]     run_len;
    logic [ROWS*CL_W-1:0] cbg;

    logic                 cfg_ready, busy, armed, done;
    logic [ROWS*RQ_W-1:0] r_req;
    logic [ROWS*WQ_W-1:0] w_req;
    logic [ROWS*AB_W-1:0] lsu;

    logic                 cfg_ready_p, busy_p, armed_p, done_p;
    logic [ROWS*RQ_W-1:0] r_req_p;
    logic [ROWS*WQ_W-1:0] w_req_p;
    logic [ROWS*AB_W-1:0] lsu_p;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    cfg_vec_t cfg_tab[ROWS];
    run_vec_t run_tab[5];

    pe_array_seq #(
        .ROWS(ROWS), .DATA_W(DATA_W), .CFG_W(CFG_W), .WORD_W(WORD_W), .CL_W(CL_W),
        .RQ_W(RQ_W), .WQ_W(WQ_W), .AB_W(AB_W), .PIPE_NS(0), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .cfg_data(cfg_data), .run_req(run_req), .run_len(run_len),
        .busy(busy), .armed(armed), .done(done), .CBG_to_LSU_bus(cbg),
        .R_request(r_req), .W_request(w_req), .LSU_addr_bus(lsu)
    );

    pe_array_seq #(
        .ROWS(ROWS), .DATA_W(DATA_W), .CFG_W(CFG_W), .WORD_W(WORD_W), .CL_W(CL_W),
        .RQ_W(RQ_W), .WQ_W(WQ_W), .AB_W(AB_W), .PIPE_NS(1), .LEN_W(LEN_W)
    ) dut_p (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready_p), .cfg_data(cfg_data), .run_req(run_req), .run_len(run_len),
        .busy(busy_p), .armed(armed_p), .done(done_p), .CBG_to_LSU_bus(cbg),
        .R_request(r_req_p), .W_request(w_req_p), .LSU_addr_bus(lsu_p)
    );

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CFG_W-1:0] cfg_of(input logic [ROWS*AB_W-1:0] bus, input int r);
        return bus[r*AB_W +: CFG_W];
    endfunction

    function automatic logic [DATA_W-1:0] nin_of(input logic [ROWS*AB_W-1:0] bus, input int r);
        return bus[r*AB_W + NIN_LSB +: DATA_W];
    endfunction

    function automatic logic [DATA_W-1:0] sin_of(input logic [ROWS*AB_W-1:0] bus, input int r);
        return bus[r*AB_W + SIN_LSB +: DATA_W];
    endfunction

    // Three consecutive beats starting at b, beat 0 least significant, top bits dropped.
    function automatic logic [CFG_W-1:0] exp_cfg(input logic [31:0] b);
        logic [95:0] w;
        w = {b + 32'd2, b + 32'd1, b};
        return w[CFG_W-1:0];
    endfunction

    task automatic load_all(input logic [31:0] base, input bit gaps);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("load_ready", cfg_ready, 1'b1);
        check("load_busy", busy, 1'b1);
        for (int i = 0; i < 12; i++) begin
            if (gaps) begin
                cfg_valid = 1'b0;
                tick();
                check("gap_ready", cfg_ready, 1'b1);
            end
            cfg_valid = 1'b1;
            cfg_data  = base + 32'(i);
            tick();
        end
        cfg_valid = 1'b0;
        check("init_on", w_req, {(ROWS*WQ_W){1'b1}});
        check("init_not_armed", armed, 1'b0);
        check("init_no_ready", cfg_ready, 1'b0);
        tick();
        check("init_off", w_req, '0);
        check("armed", armed, 1'b1);
        check("armed_p", armed_p, 1'b1);
        check("armed_not_busy", busy, 1'b0);
        for (int r = 0; r < ROWS; r++) begin
            check($sformatf("cfg_row%0d", r), cfg_of(lsu, r), exp_cfg(base + 32'(3*r)));
            check($sformatf("cfg_p_row%0d", r), cfg_of(lsu_p, r), exp_cfg(base + 32'(3*r)));
        end
    endtask

    task automatic run_and_check(input int len, input bit poke);
        int  cnt;
        bit  got;
        run_len = LEN_W'(len);
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        exp_q.push_back(len);
        cnt = 0;
        got = 1'b0;
        for (int k = 0; k < len + 10 && !got; k++) begin
            start = poke && (k == 1);
            if (done) begin
                got = 1'b1;
                check("run_cycles", cnt, exp_q.pop_front());
                check("done_armed", armed, 1'b1);
                check("done_run_off", r_req, '0);
                check("done_p", done_p, 1'b1);
            end else if (&r_req) begin
                cnt++;
            end
            tick();
        end
        start = 1'b0;
        if (!got) begin
            check("done_timeout", 1'b0, 1'b1);
            exp_q.delete();
        end
        check("done_one_cycle", done, 1'b0);
        check("armed_after_run", armed, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        cfg_tab[0] = '{0, 80'h0003_00000002_00000001};
        cfg_tab[1] = '{1, 80'h0006_00000005_00000004};
        cfg_tab[2] = '{2, 80'h0009_00000008_00000007};
        cfg_tab[3] = '{3, 80'h000C_0000000B_0000000A};
        run_tab[0] = '{5, 1'b0, 5};
        run_tab[1] = '{0, 1'b0, 0};
        run_tab[2] = '{1, 1'b0, 1};
        run_tab[3] = '{3, 1'b1, 3};
        run_tab[4] = '{12, 1'b1, 12};

        rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_valid = 1'b0;
        cfg_data = '0; run_req = 1'b0; run_len = '0; cbg = '0;
        repeat (3) tick();
        check("rst_ready", cfg_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_armed", armed, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_run", r_req, '0);
        check("rst_init", w_req, '0);
        for (int r = 0; r < ROWS; r++) begin
            check($sformatf("rst_cfg%0d", r), cfg_of(lsu, r), '0);
        end
        rst = 1'b0;
        tick();

        // run_req is ignored while idle
        run_req = 1'b1;
        run_len = 16'd3;
        tick();
        run_req = 1'b0;
        check("idle_runreq_busy", busy, 1'b0);
        check("idle_runreq_run", r_req, '0);

        load_all(32'h1, 1'b0);
        for (int i = 0; i < ROWS; i++) begin
            check($sformatf("tab_cfg%0d", cfg_tab[i].row), cfg_of(lsu, cfg_tab[i].row), cfg_tab[i].cfg);
        end

        for (int i = 0; i < 5; i++) begin
            run_and_check(run_tab[i].run_len, run_tab[i].poke_start);
            check($sformatf("tab_run%0d_q", i), exp_q.size(), 0);
            check($sformatf("tab_run%0d_len", i), run_tab[i].exp_cycles, run_tab[i].run_len);
        end

        // start beats run_req when both arrive together in ARMED
        start = 1'b1; run_req = 1'b1; run_len = 16'd4;
        tick();
        start = 1'b0; run_req = 1'b0;
        check("start_wins_ready", cfg_ready, 1'b1);
        check("start_wins_run", r_req, '0);
        check("start_wins_armed", armed, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_load_busy", busy, 1'b0);
        check("abort_load_ready", cfg_ready, 1'b0);
        check("abort_keeps_cfg", cfg_of(lsu, 3), cfg_tab[3].cfg);

        load_all(32'h50, 1'b0);
        load_all(32'h1, 1'b1);
        for (int i = 0; i < ROWS; i++) begin
            check($sformatf("gap_tab_cfg%0d", i), cfg_of(lsu, cfg_tab[i].row), cfg_tab[i].cfg);
        end

        // abort in the middle of a run
        run_len = 16'd20;
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        repeat (3) tick();
        check("midrun_on", r_req, {(ROWS*RQ_W){1'b1}});
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_run_off", r_req, '0);
        check("abort_run_busy", busy, 1'b0);
        check("abort_run_armed", armed, 1'b0);
        check("abort_run_done", done, 1'b0);
        tick();
        check("abort_run_nodone", done, 1'b0);

        // abort after 7 beats: rows 0-1 take the new words, rows 2-3 keep the old ones
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            cfg_valid = 1'b1;
            cfg_data  = 32'h100 + 32'(i);
            tick();
        end
        cfg_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort7_busy", busy, 1'b0);
        check("abort7_ready", cfg_ready, 1'b0);
        check("abort7_row0", cfg_of(lsu, 0), 80'h0102_00000101_00000100);
        check("abort7_row1", cfg_of(lsu, 1), exp_cfg(32'h103));
        check("abort7_row2", cfg_of(lsu, 2), cfg_tab[2].cfg);
        check("abort7_row3", cfg_of(lsu, 3), cfg_tab[3].cfg);
        cfg_valid = 1'b1;
        cfg_data  = 32'hFFFF_FFFF;
        tick();
        cfg_valid = 1'b0;
        check("idle_cfg_ignored", cfg_of(lsu, 2), cfg_tab[2].cfg);
        load_all(32'h200, 1'b0);

        // N/S links: same cycle without pipe, one cycle later with pipe
        cbg = {32'h0, 32'hCAFE_F00D, 32'hDEAD_BEEF, 32'h1234_5678};
        #1;
        check("link_row0_sin", sin_of(lsu, 0), 32'hDEAD_BEEF);
        check("link_row0_nin", nin_of(lsu, 0), 32'h0);
        check("link_row1_nin", nin_of(lsu, 1), 32'hEDCB_A987);
        check("link_row1_sin", sin_of(lsu, 1), 32'hCAFE_F00D);
        check("link_row3_sin", sin_of(lsu, 3), 32'h0);
        check("pipe_row0_sin_old", sin_of(lsu_p, 0), 32'h0);
        check("pipe_row1_nin_old", nin_of(lsu_p, 1), 32'hFFFF_FFFF);
        tick();
        check("pipe_row0_sin", sin_of(lsu_p, 0), 32'hDEAD_BEEF);
        check("pipe_row1_nin", nin_of(lsu_p, 1), 32'hEDCB_A987);
        check("pipe_row2_nin", nin_of(lsu_p, 2), 32'h2152_4110);
        check("pipe_row0_nin", nin_of(lsu_p, 0), 32'h0);

        // synchronous reset 40 cycles into a 100-cycle run
        run_len = 16'd100;
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        repeat (39) tick();
        check("run40_on", r_req, {(ROWS*RQ_W){1'b1}});
        rst = 1'b1;
        tick();
        check("rstrun_run", r_req, '0);
        check("rstrun_run_p", r_req_p, '0);
        check("rstrun_busy", busy, 1'b0);
        check("rstrun_armed", armed, 1'b0);
        check("rstrun_done", done, 1'b0);
        for (int r = 0; r < ROWS; r++) begin
            check($sformatf("rstrun_cfg%0d", r), cfg_of(lsu, r), '0);
            check($sformatf("rstrun_cfg_p%0d", r), cfg_of(lsu_p, r), '0);
        end
        check("rstrun_pipe_sin", sin_of(lsu_p, 0), 32'h0);
        rst = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
